// File: rtl/program_loader.sv
// program_loader: frames a UART byte stream into 24-bit words, loads them into
// instruction RAM from address 0, verifies the checksum and holds the CPU meanwhile.
module program_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [23:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            sum_q, sum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic                  acc, expired;
  assign rx_ready  = state_q != WRITE;
  assign acc       = rx_valid && rx_ready;
  assign expired   = !acc && (state_q inside {COUNT, DATA, CHECK}) && tmo_q == TW'(TIMEOUT - 1);
  assign mem_we    = state_q == WRITE;
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign cpu_hold  = hold_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign error     = err_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    sum_d   = sum_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    tmo_d   = (acc || state_q == IDLE || state_q == WRITE) ? '0 : tmo_q + 1'b1;
    case (state_q)
      IDLE: if (acc && rx_data == SYNC_BYTE) begin
        state_d = COUNT;
        done_d  = 1'b0;
        err_d   = 1'b0;
        hold_d  = 1'b1;
        addr_d  = '0;
        idx_d   = '0;
        sum_d   = '0;
      end
      COUNT: if (acc) begin
        cnt_d   = ADDR_WIDTH'(rx_data);
        sum_d   = rx_data;
        state_d = DATA;
      end
      DATA: if (acc) begin
        word_d  = {word_q[15:0], rx_data};
        sum_d   = sum_q + rx_data;
        idx_d   = idx_q == 2'd2 ? 2'd0 : idx_q + 1'b1;
        state_d = idx_q == 2'd2 ? WRITE : DATA;
      end
      // a count of 0 wraps so that the last word sits at the top address
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        state_d = addr_q == cnt_q - 1'b1 ? CHECK : DATA;
      end
      CHECK: if (acc) begin
        done_d  = rx_data == sum_q;
        err_d   = rx_data != sum_q;
        hold_d  = rx_data != sum_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (expired) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames; expected RAM writes go to a scoreboard queue
// checked by a monitor, status outputs are checked directly after each step.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        rst, rx_valid, rx_ready, mem_we, cpu_hold, busy, done, error;
  logic [7:0]  rx_data, mem_addr;
  logic [23:0] mem_wdata;
  logic [31:0] sb[$];
  int          n_vec = 0, n_err = 0;

  program_loader #(.ADDR_WIDTH(8), .SYNC_BYTE(8'hA5), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_we) begin
      chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
      if (sb.size() == 0) chk("unexpected_write", {mem_addr, mem_wdata}, 32'hxxxxxxxx);
      else chk("mem_write", {mem_addr, mem_wdata}, sb.pop_front());
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string nm, input logic [3:0] e);
    chk(nm, {28'd0, done, error, cpu_hold, busy}, {28'd0, e});
  endtask

  task automatic frame_a(input logic [7:0] ck);
    logic [7:0] body [7] = '{8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    sb.push_back({8'd0, 24'h123456});
    sb.push_back({8'd1, 24'hABCDEF});
    send(8'hA5);
    status("after_sync", 4'b0011);
    foreach (body[i]) send(body[i]);
    send(ck);
    rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", {rx_ready, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b0, 8'd0, 24'd0});
    status("reset_status", 4'b0000);
    send(8'h00);
    send(8'h3C);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    status("idle_discard", 4'b0000);
    // checksum 02+12+34+56+AB+CD+EF = 0x305 -> 0x05
    frame_a(8'h05);
    status("frame_ok", 4'b1000);
    frame_a(8'h04);
    status("frame_bad_ck", 4'b0110);
    frame_a(8'h05);
    status("frame_recover", 4'b1000);
    send(8'hA5); send(8'h01); send(8'h11);
    rx_valid = 1'b0;
    repeat (49) @(posedge clk);
    #1 status("before_timeout", 4'b0011);
    @(posedge clk); #1;
    status("timeout", 4'b0110);
    for (int a = 0; a < 256; a++) sb.push_back({a[7:0], 24'h010101});
    send(8'hA5); send(8'h00);
    for (int i = 0; i < 768; i++) send(8'h01);
    send(8'h00);
    rx_valid = 1'b0;
    status("n0_done", 4'b1000);
    chk("n0_addr_wrap", {24'd0, mem_addr}, 32'd0);
    sb.push_back({8'd0, 24'h010203});
    send(8'hA5); send(8'h02);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    rx_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {rx_ready, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b0, 8'd0, 24'd0});
    status("async_rst_status", 4'b0000);
    @(posedge clk); #1 rst = 1'b0;
    frame_a(8'h05);
    status("after_rst_frame", 4'b1000);
    @(posedge clk); #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
